// File: rtl/ctrl_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sched_pkg
//  Description : Shared types and constants for the control-register write
//                scheduler: sequencer state encoding, deferred-queue default
//                depth and the {wa, data} queue entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_sched_pkg;

    // Default log2 of the deferred queue depth (8 entries)
    localparam int c_depth_log2_dflt = 3;

    // Sequencer state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_lo   = 2'd1;
    localparam state_t c_st_hi   = 2'd2;

    // One queued register write: 2-bit select over 32-bit data (34 bits)
    typedef struct packed {
        logic [1:0]  wa;
        logic [31:0] data;
    } entry_t;

    function automatic entry_t make_entry(input logic [1:0] wa, input logic [31:0] data);
        entry_t e;
        e.wa   = wa;
        e.data = data;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_sched_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sched_fifo
//  Description : Synchronous deferred-write queue with one push port, one pop
//                port and an occupancy count. A push into a full queue is
//                dropped and flagged, even when a pop happens on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_sched_fifo
    import ctrl_sched_pkg::*;
#(
    parameter int DEPTH_LOG2 = c_depth_log2_dflt
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  entry_t              i_push_entry,
    input  logic                i_pop,
    output entry_t              o_head,
    output logic [DEPTH_LOG2:0] o_count,
    output logic                o_full,
    output logic                o_drop
);

    localparam int unsigned               c_depth_int = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]       c_depth     = c_depth_int[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2-1:0]     c_ptr_one   = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]       c_cnt_one   = (DEPTH_LOG2+1)'(1);

    entry_t                r_mem [c_depth_int];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // Fullness is judged on the registered count, so a same-edge pop never
    // makes room for a push into a full queue.
    assign o_full    = (r_count == c_depth);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign o_drop    = i_push && o_full;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Entry storage; validity is defined by the pointers, so no reset needed
    always_ff @(negedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointers wrap modulo depth; the count saturates naturally at depth
    always_ff @(negedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_write_sched
//  Description : Control-register write scheduler. Arbitrates between an
//                immediate write port and a frame-released deferred queue and
//                issues every 32-bit write as a LO/HI pair of 16-bit cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_write_sched
    import ctrl_sched_pkg::*;
#(
    parameter int DEPTH_LOG2 = c_depth_log2_dflt
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                imm_req,
    input  logic [1:0]          imm_wa,
    input  logic [31:0]         imm_data,
    output logic                imm_ack,
    input  logic                def_we,
    input  logic [1:0]          def_wa,
    input  logic [31:0]         def_data,
    output logic                def_full,
    output logic [DEPTH_LOG2:0] def_count,
    input  logic                frame_sync,
    output logic                wen,
    output logic [1:0]          wa,
    output logic [15:0]         di,
    output logic                busy,
    output logic                overflow
);

    state_t              r_state;
    state_t              w_state_nxt;
    entry_t              r_cur;
    logic                r_cur_def;
    logic [DEPTH_LOG2:0] r_pending;
    logic                r_overflow;

    entry_t              w_push_entry;
    entry_t              w_head;
    logic [DEPTH_LOG2:0] w_fifo_count;
    logic                w_fifo_drop;
    logic                w_pop;
    logic [DEPTH_LOG2:0] w_pend_base;
    logic [DEPTH_LOG2:0] w_pend_nxt;
    logic                w_grant_slot;
    logic                w_grant_def;
    logic                w_grant_imm;

    assign w_push_entry = make_entry(def_wa, def_data);

    ctrl_sched_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk          (sclk),
        .rst          (rst),
        .i_push       (def_we),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_fifo_count),
        .o_full       (def_full),
        .o_drop       (w_fifo_drop)
    );

    // A deferred entry stays at the queue head through its LO cycle and
    // leaves on the edge that ends LO.
    assign w_pop = (r_state == c_st_lo) && r_cur_def;

    // frame_sync snapshots the pre-push occupancy; the same-edge pop is then
    // removed so an entry already in flight is never released twice.
    assign w_pend_base = frame_sync ? w_fifo_count : r_pending;
    assign w_pend_nxt  = w_pend_base - {{DEPTH_LOG2{1'b0}}, w_pop};

    // Grants are taken only when the sequencer can start a new LO next cycle.
    // Using the post-snapshot count lets a frame_sync start a drain at once.
    assign w_grant_slot = (r_state == c_st_idle) || (r_state == c_st_hi);
    assign w_grant_def  = w_grant_slot && (w_pend_nxt != '0);
    assign w_grant_imm  = w_grant_slot && !w_grant_def && imm_req;

    // Sequencer state register
    always_ff @(negedge sclk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state: LO always runs into HI, HI chains to another LO
    always_comb begin
        w_state_nxt = c_st_idle;
        case (r_state)
            c_st_idle: w_state_nxt = (w_grant_def || w_grant_imm) ? c_st_lo : c_st_idle;
            c_st_lo:   w_state_nxt = c_st_hi;
            c_st_hi:   w_state_nxt = (w_grant_def || w_grant_imm) ? c_st_lo : c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Capture the granted write, track released entries, latch overflow
    always_ff @(negedge sclk) begin
        if (rst) begin
            r_cur      <= '0;
            r_cur_def  <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            if (w_grant_def) begin
                r_cur     <= w_head;
                r_cur_def <= 1'b1;
            end else if (w_grant_imm) begin
                r_cur     <= make_entry(imm_wa, imm_data);
                r_cur_def <= 1'b0;
            end
            if (w_fifo_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Register-bus outputs; forced quiet while rst is high so a write caught
    // in HI never drives its upper half.
    always_comb begin
        wen     = 1'b0;
        wa      = 2'd0;
        di      = 16'd0;
        imm_ack = 1'b0;
        if (!rst) begin
            case (r_state)
                c_st_lo: begin
                    wen     = 1'b1;
                    wa      = r_cur.wa;
                    di      = r_cur.data[15:0];
                    imm_ack = !r_cur_def;
                end
                c_st_hi: begin
                    di = r_cur.data[31:16];
                end
                default: begin
                    di = 16'd0;
                end
            endcase
        end
    end

    assign busy      = !rst && ((r_state != c_st_idle) || (r_pending != '0));
    assign overflow  = r_overflow;
    assign def_count = w_fifo_count;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_write_sched
//  Description : Directed self-checking bench for ctrl_write_sched. Inputs are
//                driven on posedge sclk, outputs sampled on posedge sclk (the
//                design updates on negedge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_write_sched;

    logic        sclk = 1'b0;
    logic        rst;
    logic        imm_req;
    logic [1:0]  imm_wa;
    logic [31:0] imm_data;
    logic        imm_ack;
    logic        def_we;
    logic [1:0]  def_wa;
    logic [31:0] def_data;
    logic        def_full;
    logic [3:0]  def_count;
    logic        frame_sync;
    logic        wen;
    logic [1:0]  wa;
    logic [15:0] di;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Observed writes as {wa, hi, lo}, and imm_ack pulse count
    logic [33:0] obs_q[$];
    int          ack_cnt  = 0;
    logic        mon_pend = 1'b0;
    logic [1:0]  mon_wa   = 2'd0;
    logic [15:0] mon_lo   = 16'd0;

    ctrl_write_sched #(
        .DEPTH_LOG2 (3)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .imm_req    (imm_req),
        .imm_wa     (imm_wa),
        .imm_data   (imm_data),
        .imm_ack    (imm_ack),
        .def_we     (def_we),
        .def_wa     (def_wa),
        .def_data   (def_data),
        .def_full   (def_full),
        .def_count  (def_count),
        .frame_sync (frame_sync),
        .wen        (wen),
        .wa         (wa),
        .di         (di),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 sclk = ~sclk;

    // Write monitor: LO half and select on the wen cycle, HI half one cycle later
    always @(posedge sclk) begin
        if (mon_pend) begin
            obs_q.push_back({mon_wa, di, mon_lo});
            mon_pend = 1'b0;
        end
        if (wen === 1'b1) begin
            mon_pend = 1'b1;
            mon_wa   = wa;
            mon_lo   = di;
        end
        if (imm_ack === 1'b1) ack_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge sclk);
    endtask

    task automatic clear_mon();
        #1;
        obs_q.delete();
        ack_cnt  = 0;
        mon_pend = 1'b0;
    endtask

    task automatic push_one(input logic [1:0] a, input logic [31:0] d);
        def_we = 1'b1; def_wa = a; def_data = d;
        cyc();
        def_we = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_sync = 1'b1;
        cyc();
        frame_sync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", wen); end
        checks++; if (wa !== 2'd0) begin errors++; $display("FAIL rst_wa got %h exp 0", wa); end
        checks++; if (di !== 16'd0) begin errors++; $display("FAIL rst_di got %h exp 0", di); end
        checks++; if (imm_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", imm_ack); end
        checks++; if (def_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", def_count); end
        checks++; if (def_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", def_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        rst = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    endtask

    task automatic test_imm();
        clear_mon();
        imm_req = 1'b1; imm_wa = 2'd1; imm_data = 32'h0000_0014;
        cyc();
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL imm_lo_wen got %b exp 1", wen); end
        checks++; if (wa !== 2'd1) begin errors++; $display("FAIL imm_lo_wa got %h exp 1", wa); end
        checks++; if (di !== 16'h0014) begin errors++; $display("FAIL imm_lo_di got %h exp 0014", di); end
        checks++; if (imm_ack !== 1'b1) begin errors++; $display("FAIL imm_ack got %b exp 1", imm_ack); end
        imm_req = 1'b0; imm_wa = 2'd3; imm_data = 32'hFFFF_FFFF;
        cyc();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL imm_hi_wen got %b exp 0", wen); end
        checks++; if (di !== 16'h0000) begin errors++; $display("FAIL imm_hi_di got %h exp 0000", di); end
        checks++; if (wa !== 2'd0) begin errors++; $display("FAIL imm_hi_wa got %h exp 0", wa); end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL imm_idle_busy got %b exp 0", busy); end
        checks++; if (ack_cnt != 1) begin errors++; $display("FAIL imm_ack_count got %0d exp 1", ack_cnt); end
    endtask

    task automatic test_deferred();
        logic        exp_wen [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  exp_wa  [6] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
        logic [15:0] exp_di  [6] = '{16'hAAAA, 16'h1111, 16'hBBBB, 16'h2222, 16'hCCCC, 16'h3333};
        clear_mon();
        push_one(2'd0, 32'h1111_AAAA);
        push_one(2'd2, 32'h2222_BBBB);
        push_one(2'd3, 32'h3333_CCCC);
        checks++; if (def_count !== 4'd3) begin errors++; $display("FAIL def_count3 got %0d exp 3", def_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL def_busy_queued got %b exp 0", busy); end
        repeat (100) cyc();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL def_no_release got %0d writes exp 0", obs_q.size()); end
        pulse_fs();
        for (int i = 0; i < 6; i++) begin
            checks++; if (wen !== exp_wen[i]) begin errors++; $display("FAIL def_wen[%0d] got %b exp %b", i, wen, exp_wen[i]); end
            checks++; if (wa !== exp_wa[i]) begin errors++; $display("FAIL def_wa[%0d] got %h exp %h", i, wa, exp_wa[i]); end
            checks++; if (di !== exp_di[i]) begin errors++; $display("FAIL def_di[%0d] got %h exp %h", i, di, exp_di[i]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL def_busy[%0d] got %b exp 1", i, busy); end
            cyc();
        end
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL def_end_wen got %b exp 0", wen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL def_end_busy got %b exp 0", busy); end
        checks++; if (def_count !== 4'd0) begin errors++; $display("FAIL def_end_count got %0d exp 0", def_count); end
    endtask

    task automatic test_priority();
        logic        exp_wen [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  exp_wa  [6] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
        logic [15:0] exp_di  [6] = '{16'h0202, 16'h0101, 16'h0404, 16'h0303, 16'hF00D, 16'hCAFE};
        logic        exp_ack [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        push_one(2'd1, 32'h0101_0202);
        push_one(2'd2, 32'h0303_0404);
        imm_req = 1'b1; imm_wa = 2'd3; imm_data = 32'hCAFE_F00D;
        pulse_fs();
        for (int i = 0; i < 6; i++) begin
            checks++; if (wen !== exp_wen[i]) begin errors++; $display("FAIL pri_wen[%0d] got %b exp %b", i, wen, exp_wen[i]); end
            checks++; if (wa !== exp_wa[i]) begin errors++; $display("FAIL pri_wa[%0d] got %h exp %h", i, wa, exp_wa[i]); end
            checks++; if (di !== exp_di[i]) begin errors++; $display("FAIL pri_di[%0d] got %h exp %h", i, di, exp_di[i]); end
            checks++; if (imm_ack !== exp_ack[i]) begin errors++; $display("FAIL pri_ack[%0d] got %b exp %b", i, imm_ack, exp_ack[i]); end
            if (imm_ack === 1'b1) imm_req = 1'b0;
            cyc();
        end
        imm_req = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pri_end_busy got %b exp 0", busy); end
    endtask

    task automatic test_overflow();
        logic [15:0] hi;
        logic [15:0] lo;
        logic [33:0] got;
        clear_mon();
        for (int k = 0; k < 8; k++) begin
            hi = 16'hA000 + 16'(k);
            lo = 16'h5000 + 16'(k);
            push_one(2'(k), {hi, lo});
        end
        checks++; if (def_count !== 4'd8) begin errors++; $display("FAIL ovf_count8 got %0d exp 8", def_count); end
        checks++; if (def_full !== 1'b1) begin errors++; $display("FAIL ovf_full8 got %b exp 1", def_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag8 got %b exp 0", overflow); end
        push_one(2'd1, 32'h9999_9999);
        checks++; if (def_count !== 4'd8) begin errors++; $display("FAIL ovf_count9 got %0d exp 8", def_count); end
        checks++; if (def_full !== 1'b1) begin errors++; $display("FAIL ovf_full9 got %b exp 1", def_full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag9 got %b exp 1", overflow); end
        pulse_fs();
        repeat (20) cyc();
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL ovf_writes got %0d exp 8", obs_q.size()); end
        for (int k = 0; k < 8; k++) begin
            hi  = 16'hA000 + 16'(k);
            lo  = 16'h5000 + 16'(k);
            got = (k < obs_q.size()) ? obs_q[k] : 34'h0;
            checks++; if (got !== {2'(k), hi, lo}) begin errors++; $display("FAIL ovf_write[%0d] got %h exp %h", k, got, {2'(k), hi, lo}); end
        end
        checks++; if (def_count !== 4'd0) begin errors++; $display("FAIL ovf_end_count got %0d exp 0", def_count); end
        checks++; if (def_full !== 1'b0) begin errors++; $display("FAIL ovf_end_full got %b exp 0", def_full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_fs_push();
        logic [33:0] got;
        clear_mon();
        push_one(2'd0, 32'h0001_0010);
        push_one(2'd1, 32'h0002_0020);
        push_one(2'd2, 32'h0003_0030);
        frame_sync = 1'b1; def_we = 1'b1; def_wa = 2'd3; def_data = 32'h0004_0040;
        cyc();
        frame_sync = 1'b0; def_we = 1'b0;
        repeat (10) cyc();
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL fsp_writes got %0d exp 3", obs_q.size()); end
        got = (obs_q.size() > 2) ? obs_q[2] : 34'h0;
        checks++; if (got !== {2'd2, 16'h0003, 16'h0030}) begin errors++; $display("FAIL fsp_third got %h exp %h", got, {2'd2, 16'h0003, 16'h0030}); end
        checks++; if (def_count !== 4'd1) begin errors++; $display("FAIL fsp_left got %0d exp 1", def_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fsp_busy got %b exp 0", busy); end
        pulse_fs();
        repeat (5) cyc();
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL fsp_writes2 got %0d exp 4", obs_q.size()); end
        got = (obs_q.size() > 3) ? obs_q[3] : 34'h0;
        checks++; if (got !== {2'd3, 16'h0004, 16'h0040}) begin errors++; $display("FAIL fsp_fourth got %h exp %h", got, {2'd3, 16'h0004, 16'h0040}); end
        // A second frame_sync while the first entry is in its LO cycle
        clear_mon();
        push_one(2'd1, 32'h0005_0050);
        push_one(2'd2, 32'h0006_0060);
        pulse_fs();
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL resnap_lo got %b exp 1", wen); end
        pulse_fs();
        repeat (8) cyc();
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL resnap_writes got %0d exp 2", obs_q.size()); end
        checks++; if (def_count !== 4'd0) begin errors++; $display("FAIL resnap_count got %0d exp 0", def_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL resnap_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        push_one(2'd0, 32'h7777_1234);
        push_one(2'd1, 32'h8888_5678);
        pulse_fs();
        cyc();
        checks++; if (di !== 16'h7777) begin errors++; $display("FAIL rmid_hi_di got %h exp 7777", di); end
        rst = 1'b1;
        #1;
        checks++; if (di !== 16'h0000) begin errors++; $display("FAIL rmid_abort_di got %h exp 0000", di); end
        cyc();
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rmid_wen got %b exp 0", wen); end
        checks++; if (di !== 16'h0000) begin errors++; $display("FAIL rmid_di got %h exp 0000", di); end
        checks++; if (def_count !== 4'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", def_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b exp 0", overflow); end
        rst = 1'b0;
        clear_mon();
        repeat (10) cyc();
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_replay got %0d writes exp 0", obs_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        imm_req = 1'b1; imm_wa = 2'd2; imm_data = 32'h1357_2468;
        cyc();
        checks++; if (wen !== 1'b1 || wa !== 2'd2 || di !== 16'h2468) begin errors++; $display("FAIL rmid_new_lo got wen %b wa %h di %h exp 1 2 2468", wen, wa, di); end
        imm_req = 1'b0;
        cyc();
        checks++; if (di !== 16'h1357) begin errors++; $display("FAIL rmid_new_hi got %h exp 1357", di); end
    endtask

    initial begin
        rst = 1'b1; imm_req = 1'b0; imm_wa = 2'd0; imm_data = 32'd0;
        def_we = 1'b0; def_wa = 2'd0; def_data = 32'd0; frame_sync = 1'b0;
        test_reset();
        test_imm();
        test_deferred();
        test_priority();
        test_overflow();
        test_fs_push();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_write_sched.md
CTRL_WRITE_SCHED -- requirements
Module: ctrl_write_sched

Interface
REQ-001 Parameter DEPTH_LOG2, default 3, sets deferred FIFO depth to 2**DEPTH_LOG2 entries.
REQ-002 sclk  in  1  system clock; one clock; all state updates on negedge sclk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 imm_req  in  1  immediate write request; held until imm_ack.
REQ-005 imm_wa  in  2  immediate register select.
REQ-006 imm_data  in  32  immediate register data.
REQ-007 imm_ack  out  1  one-cycle pulse when the immediate write is issued.
REQ-008 def_we  in  1  push one deferred write.
REQ-009 def_wa  in  2  deferred register select.
REQ-010 def_data  in  32  deferred register data.
REQ-011 def_full  out  1  FIFO holds DEPTH entries.
REQ-012 def_count  out  DEPTH_LOG2+1  FIFO occupancy.
REQ-013 frame_sync  in  1  frame-start pulse; releases queued deferred writes.
REQ-014 wen  out  1  control-register write strobe.
REQ-015 wa  out  2  control-register select, valid with wen.
REQ-016 di  out  16  control-register data: low half with wen, high half the cycle after.
REQ-017 busy  out  1  state != IDLE or pending != 0.
REQ-018 overflow  out  1  sticky; set when a push is dropped.

Function
REQ-019 Each register write takes two cycles: LO (wen=1, wa, di=data[15:0]), then HI (wen=0, di=data[31:16]).
REQ-020 Writes may be issued back to back; LO may directly follow HI.
REQ-021 Outside LO/HI, wen=0, wa=0 and di=0.
REQ-022 The FSM has three states: IDLE, LO and HI.
REQ-023 FSM transitions: IDLE->LO on a grant; LO->HI always; HI->LO on a grant; HI->IDLE with no grant.
REQ-024 A grant in IDLE or HI goes to deferred when pending != 0, otherwise to immediate when imm_req=1.
REQ-025 Deferred writes are popped at LO in FIFO order, and pending decrements by one on each pop.
REQ-026 imm_ack pulses in the LO cycle of the immediate transfer; imm_wa and imm_data are captured at the grant.
REQ-027 On frame_sync, pending is set to the FIFO entry count before this edge's push, minus any pop at this edge.
REQ-028 A push in the same cycle as frame_sync waits for the next frame_sync.
REQ-029 frame_sync during a drain re-snapshots pending by the rule in REQ-027, so no entry is released twice or lost.
REQ-030 A push when def_count==DEPTH is dropped and sets overflow, even if a pop occurs in the same cycle.
REQ-031 A push and a pop in the same cycle leave def_count unchanged.
REQ-032 def_full is asserted exactly when def_count==DEPTH.
REQ-033 FIFO pointers wrap modulo DEPTH; def_count is DEPTH_LOG2+1 bits wide and never wraps.
REQ-034 Latency from imm_req in IDLE to the wen cycle is one cycle.
REQ-035 Latency from frame_sync in IDLE with pending > 0 to the first wen cycle is one cycle.

Reset
REQ-036 While rst=1: state=IDLE, wen=0, wa=0, di=0, imm_ack=0, pending=0, FIFO emptied, def_count=0, overflow=0.
REQ-037 rst during HI aborts the transfer with di=0, so the half-issued write carries no high-half enable bits.
REQ-038 Writes dropped by reset are not replayed.

Structure
REQ-039 State encoding, DEPTH_LOG2 default and the 34-bit entry layout {wa, data} belong in shared package ctrl_sched_pkg.
REQ-040 The FIFO is sub-module ctrl_sched_fifo: synchronous, one push port, one pop port, occupancy output.
REQ-041 Arbitration and the LO/HI sequencer reside in ctrl_write_sched.

Verification
REQ-042 Immediate write: imm_req, wa=1, data=0x0000_0014 -> wen=1/di=0x0014 one cycle after the request, then di=0x0000; imm_ack pulses once.
REQ-043 Deferred queueing: push 3 entries, no frame_sync -> no wen for 100 cycles; frame_sync -> exactly 3 back-to-back LO/HI pairs in push order; busy deasserts after the last HI.
REQ-044 Priority: imm_req is held while a drain of 2 is pending -> both deferred writes are issued first, then the immediate write; imm_ack pulses in the 3rd LO cycle.
REQ-045 Overflow (DEPTH=8): push 9 entries -> def_count=8, def_full=1, overflow=1; after frame_sync, 8 writes are issued and the 9th is never issued.
REQ-046 frame_sync with a simultaneous push of entry 4 while 3 entries are queued -> 3 writes are issued; entry 4 is issued only after the next frame_sync.
REQ-047 Reset mid-transfer: rst asserted in HI -> wen=0 and di=0 in the next cycle, def_count=0, no further writes until new requests arrive.
